// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU pipeline types and constants
package cpu_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] R0 = 4'h0;

    // Control bits carried from ID into EX
    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       regWrite0;
        logic       md;
        logic [3:0] aluop;
    } ctrl_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/md_busy_ctr.sv
// rtl/md_busy_ctr.sv - multi-cycle multiply/divide occupancy FSM and counter
module md_busy_ctr
    import cpu_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic ex_flush,
    output logic idle,
    output logic busy_hold,
    output logic md_done
);

    localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Decode status from registered state; a flush suppresses md_done
    always_comb begin
        idle      = (state == IDLE);
        busy_hold = (state == BUSY) && (cnt != '0);
        md_done   = (state == BUSY) && (cnt == '0) && !ex_flush;
    end

    // IDLE/BUSY transitions; md_start cycle counts as the first EX cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (ex_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(MD_LAT - 2);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with load-use, flush and md hold control
module idex_stage
    import cpu_pkg::*;
#(
    parameter int DW     = 16,
    parameter int MD_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rr1,
    input  logic [REG_W-1:0] id_rr2,
    input  logic [DW-1:0]    id_rd1,
    input  logic [DW-1:0]    id_rd2,
    input  logic [DW-1:0]    id_imm,
    input  logic [3:0]       id_aluop,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_memWrite,
    input  logic             id_regWrite0,
    input  logic             id_md,
    input  logic             ex_flush,
    output logic             idex_valid,
    output logic [REG_W-1:0] idex_rr1,
    output logic [REG_W-1:0] idex_rr2,
    output logic [DW-1:0]    idex_rd1,
    output logic [DW-1:0]    idex_rd2,
    output logic [DW-1:0]    idex_imm,
    output logic [3:0]       idex_aluop,
    output logic             idex_regWrite,
    output logic             idex_memRead,
    output logic             idex_memWrite,
    output logic             idex_regWrite0,
    output logic             idex_md,
    output logic             stall_front,
    output logic             exmem_bubble,
    output logic             md_done
);

    ctrl_t idCtrl;
    ctrl_t exCtrl;
    logic  mdIdle;
    logic  busyHold;
    logic  md_start;
    logic  mdHold;
    logic  lu;

    // Pack ID control bits for a single-word register load
    always_comb begin
        idCtrl = '{regWrite:  id_regWrite,
                   memRead:   id_memRead,
                   memWrite:  id_memWrite,
                   regWrite0: id_regWrite0,
                   md:        id_md,
                   aluop:     id_aluop};
    end

    // Hazard detection: md wins over load-use when both decode bits are set
    always_comb begin
        md_start     = mdIdle && idex_valid && exCtrl.md;
        mdHold       = md_start || busyHold;
        lu           = mdIdle && !md_start && idex_valid && exCtrl.memRead &&
                       (idex_rr1 != R0) && id_valid &&
                       ((idex_rr1 == id_rr1) || (idex_rr1 == id_rr2));
        stall_front  = lu || mdHold;
        exmem_bubble = mdHold;
    end

    md_busy_ctr #(.MD_LAT(MD_LAT)) uCtr (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_start  (md_start),
        .ex_flush  (ex_flush),
        .idle      (mdIdle),
        .busy_hold (busyHold),
        .md_done   (md_done)
    );

    // ID/EX register: flush, then md hold, then load-use bubble, else load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid <= 1'b0;
            idex_rr1   <= '0;
            idex_rr2   <= '0;
            idex_rd1   <= '0;
            idex_rd2   <= '0;
            idex_imm   <= '0;
            exCtrl     <= '0;
        end else if (ex_flush || (!mdHold && lu)) begin
            idex_valid <= 1'b0;
            idex_rr1   <= '0;
            idex_rr2   <= '0;
            idex_rd1   <= '0;
            idex_rd2   <= '0;
            idex_imm   <= '0;
            exCtrl     <= '0;
        end else if (!mdHold) begin
            idex_valid <= id_valid;
            idex_rr1   <= id_rr1;
            idex_rr2   <= id_rr2;
            idex_rd1   <= id_rd1;
            idex_rd2   <= id_rd2;
            idex_imm   <= id_imm;
            exCtrl     <= id_valid ? idCtrl : '0;
        end
    end

    // Unpack registered control for the forwarding unit and EX
    always_comb begin
        idex_regWrite  = exCtrl.regWrite;
        idex_memRead   = exCtrl.memRead;
        idex_memWrite  = exCtrl.memWrite;
        idex_regWrite0 = exCtrl.regWrite0;
        idex_md        = exCtrl.md;
        idex_aluop     = exCtrl.aluop;
    end

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - directed self-checking bench for idex_stage
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_rr1, id_rr2;
    logic [15:0] id_rd1, id_rd2, id_imm;
    logic [3:0]  id_aluop;
    logic        id_regWrite, id_memRead, id_memWrite, id_regWrite0, id_md;
    logic        ex_flush;
    logic        idex_valid;
    logic [3:0]  idex_rr1, idex_rr2;
    logic [15:0] idex_rd1, idex_rd2, idex_imm;
    logic [3:0]  idex_aluop;
    logic        idex_regWrite, idex_memRead, idex_memWrite, idex_regWrite0, idex_md;
    logic        stall_front, exmem_bubble, md_done;

    int checks = 0;
    int errors = 0;

    idex_stage #(.DW(16), .MD_LAT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rr1         (id_rr1),
        .id_rr2         (id_rr2),
        .id_rd1         (id_rd1),
        .id_rd2         (id_rd2),
        .id_imm         (id_imm),
        .id_aluop       (id_aluop),
        .id_regWrite    (id_regWrite),
        .id_memRead     (id_memRead),
        .id_memWrite    (id_memWrite),
        .id_regWrite0   (id_regWrite0),
        .id_md          (id_md),
        .ex_flush       (ex_flush),
        .idex_valid     (idex_valid),
        .idex_rr1       (idex_rr1),
        .idex_rr2       (idex_rr2),
        .idex_rd1       (idex_rd1),
        .idex_rd2       (idex_rd2),
        .idex_imm       (idex_imm),
        .idex_aluop     (idex_aluop),
        .idex_regWrite  (idex_regWrite),
        .idex_memRead   (idex_memRead),
        .idex_memWrite  (idex_memWrite),
        .idex_regWrite0 (idex_regWrite0),
        .idex_md        (idex_md),
        .stall_front    (stall_front),
        .exmem_bubble   (exmem_bubble),
        .md_done        (md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] im,
                         input logic [3:0] op, input logic rw, input logic mr, input logic mw,
                         input logic md);
        id_valid     = v;
        id_rr1       = r1;
        id_rr2       = r2;
        id_rd1       = d1;
        id_rd2       = d2;
        id_imm       = im;
        id_aluop     = op;
        id_regWrite  = rw;
        id_memRead   = mr;
        id_memWrite  = mw;
        id_regWrite0 = 1'b0;
        id_md        = md;
    endtask

    initial begin
        rst_n    = 1'b0;
        ex_flush = 1'b0;
        setId(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_valid", idex_valid, 0);
        chk("rst_stall", stall_front, 0);
        chk("rst_bubble", exmem_bubble, 0);
        chk("rst_done", md_done, 0);
        rst_n = 1'b1;

        // Load R3 enters EX
        setId(1'b1, 4'd3, 4'd1, 16'hAAAA, 16'h1111, 16'h0010, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ld_valid", idex_valid, 1);
        chk("ld_rr1", idex_rr1, 3);
        chk("ld_memRead", idex_memRead, 1);
        chk("ld_rd1", idex_rd1, 16'hAAAA);
        chk("ld_imm", idex_imm, 16'h0010);

        // Consumer uses R3 as rr2: one stall, one bubble
        setId(1'b1, 4'd6, 4'd3, 16'h6666, 16'h3333, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_stall", stall_front, 1);
        chk("lu_exmem", exmem_bubble, 0);
        tick();
        chk("lu_bub_valid", idex_valid, 0);
        chk("lu_bub_memRead", idex_memRead, 0);
        chk("lu_bub_rr1", idex_rr1, 0);
        chk("lu_after_stall", stall_front, 0);
        tick();
        chk("lu_cons_valid", idex_valid, 1);
        chk("lu_cons_rr2", idex_rr2, 3);
        chk("lu_cons_rw", idex_regWrite, 1);

        // Load R0 then use of R0: no stall
        setId(1'b1, 4'd0, 4'd2, 16'h0, 16'h0, 16'h4, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        setId(1'b1, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("r0_nostall", stall_front, 0);

        // Load R3 then unrelated rr1=4 rr2=5: no stall
        setId(1'b1, 4'd3, 4'd2, 16'h0, 16'h0, 16'h4, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        setId(1'b1, 4'd4, 4'd5, 16'h0, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("nodep_nostall", stall_front, 0);
        tick();
        chk("nodep_load_rr1", idex_rr1, 4);

        // Invalid ID instruction loads with control cleared
        setId(1'b0, 4'd7, 4'd8, 16'h7, 16'h8, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("inv_valid", idex_valid, 0);
        chk("inv_rw", idex_regWrite, 0);

        // Single MUL: 3 stall cycles, md_done in the 4th, IDEX held
        setId(1'b1, 4'd2, 4'd9, 16'h1234, 16'h0005, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        setId(1'b1, 4'd10, 4'd11, 16'hBEEF, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mul_stall_c%0d", c), stall_front, 1);
            chk($sformatf("mul_exmem_c%0d", c), exmem_bubble, 1);
            chk($sformatf("mul_done_c%0d", c), md_done, 0);
            chk($sformatf("mul_hold_rd1_c%0d", c), idex_rd1, 16'h1234);
            tick();
        end
        chk("mul_done_c3", md_done, 1);
        chk("mul_stall_c3", stall_front, 0);
        chk("mul_hold_md_c3", idex_md, 1);
        tick();
        chk("mul_next_rr1", idex_rr1, 10);
        chk("mul_next_done", md_done, 0);

        // Back-to-back MULs: 8 cycles, done at cycles 4 and 8
        setId(1'b1, 4'd1, 4'd2, 16'h00A1, 16'h0, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        setId(1'b1, 4'd5, 4'd6, 16'h00B2, 16'h0, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("b2b_done_c%0d", c), md_done, (c == 3 || c == 7) ? 1 : 0);
            chk($sformatf("b2b_stall_c%0d", c), stall_front, (c == 3 || c == 7) ? 0 : 1);
            chk($sformatf("b2b_rd1_c%0d", c), idex_rd1, (c < 4) ? 16'h00A1 : 16'h00B2);
            tick();
            if (c == 3) setId(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("b2b_idle_stall", stall_front, 0);

        // Reset during BUSY
        setId(1'b1, 4'd2, 4'd9, 16'h4321, 16'h0, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        setId(1'b1, 4'd11, 4'd12, 16'h0B0B, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rbusy_pre_stall", stall_front, 1);
        rst_n = 1'b0;
        #1;
        chk("rbusy_valid", idex_valid, 0);
        chk("rbusy_md", idex_md, 0);
        chk("rbusy_rd1", idex_rd1, 0);
        chk("rbusy_stall", stall_front, 0);
        chk("rbusy_exmem", exmem_bubble, 0);
        chk("rbusy_done", md_done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rbusy_first_rr1", idex_rr1, 11);
        chk("rbusy_first_valid", idex_valid, 1);
        chk("rbusy_first_done", md_done, 0);

        // Flush coincident with load-use
        setId(1'b1, 4'd3, 4'd0, 16'h0, 16'h0, 16'h8, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        setId(1'b1, 4'd3, 4'd4, 16'h0, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_flush = 1'b1;
        #1;
        chk("fl_stall", stall_front, 1);
        tick();
        chk("fl_bub_valid", idex_valid, 0);
        chk("fl_bub_rw", idex_regWrite, 0);
        ex_flush = 1'b0;
        setId(1'b1, 4'd12, 4'd13, 16'hC0DE, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fl_new_nostall", stall_front, 0);
        tick();
        chk("fl_new_rr1", idex_rr1, 12);
        chk("fl_new_rd1", idex_rd1, 16'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
